// File: rtl/ram_responder_if.sv
// Bus bundle between a RAM requester and ram_responder.
//   ramaddr  : byte address (bits [1:0] ignored by the responder)
//   ramstore : write data
//   ramREN   : read request, level-held
//   ramWEN   : write request, level-held
//   ramload  : read data (zero outside a read ACCESS cycle)
//   ramstate : FREE=0, BUSY=1, ACCESS=2, ERROR=3
interface ram_responder_if;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramaddr, ramstore, ramREN, ramWEN,
    input  ramload, ramstate
  );

  modport slave (
    input  ramaddr, ramstore, ramREN, ramWEN,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a fixed access latency.
// A legal request spends LAT cycles in BUSY, then one cycle in ACCESS. Reads present data
// combinationally during ACCESS; writes commit at the edge that ends ACCESS if ramWEN is
// still high. Illegal requests (both enables, or out-of-range address) park the FSM in ERROR.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset (memory contents are kept)
//   bus  : ram_responder_if slave modport
module ram_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4096
) (
  input logic            CLK,
  input logic            nRST,
  ram_responder_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    StFree   = 2'd0,
    StBusy   = 2'd1,
    StAccess = 2'd2,
    StError  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] req_idx;
  logic          req_any;
  logic          req_illegal;
  logic          req_changed;
  logic          mem_we;
  logic          unused_addr_lsb;

  assign req_idx         = bus.ramaddr[AW+1:2];
  assign req_any         = bus.ramREN | bus.ramWEN;
  assign req_illegal     = (bus.ramREN & bus.ramWEN) | (req_any & (|bus.ramaddr[31:AW+2]));
  // A different word or a different direction while waiting restarts the latency.
  assign req_changed     = (req_idx != addr_q) | (bus.ramWEN != wr_q);
  assign unused_addr_lsb = ^bus.ramaddr[1:0];

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StFree;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    if (!req_any) begin
      state_d = StFree;
    end else if (req_illegal) begin
      state_d = StError;
    end else if (state_q == StBusy && !req_changed) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end
      // Counter reaching zero at this edge ends the BUSY phase.
      if (cnt_q <= 4'd1) begin
        state_d = StAccess;
      end
    end else begin
      // New request: from FREE, ERROR, ACCESS (held request) or a changed BUSY request.
      addr_d  = req_idx;
      wr_d    = bus.ramWEN;
      cnt_d   = LAT_CNT;
      state_d = (LAT_CNT == 4'd0) ? StAccess : StBusy;
    end
  end

  // Outputs
  always_comb begin
    bus.ramstate = state_q;
    bus.ramload  = 32'h0;
    if (state_q == StAccess && !wr_q) begin
      bus.ramload = mem_q[addr_q];
    end
  end

  // Write commits as ACCESS ends; reset forces FREE, so an aborted access never writes.
  assign mem_we = (state_q == StAccess) & wr_q & bus.ramWEN;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= bus.ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: one LAT=2 and one LAT=0 instance, directed stimulus, a
// request-age reference model checked every falling edge, plus literal expectations.
module tb_ram_responder;

  logic CLK = 1'b0;
  logic nrst2;
  logic nrst0;

  ram_responder_if b2 ();
  ram_responder_if b0 ();

  ram_responder #(.LAT(2), .DEPTH(4096)) u_dut2 (.CLK(CLK), .nRST(nrst2), .bus(b2.slave));
  ram_responder #(.LAT(0), .DEPTH(4096)) u_dut0 (.CLK(CLK), .nRST(nrst0), .bus(b0.slave));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference model: index 0 = LAT=2 instance, index 1 = LAT=0 instance.
  // A legal request is ACCESS once it has been held unchanged for LAT edges past its start.
  int          m_lat [2] = '{2, 0};
  int          m_st  [2] = '{0, 0};
  int          m_age [2] = '{0, 0};
  int          m_idx [2] = '{0, 0};
  bit          m_wr  [2] = '{1'b0, 1'b0};
  logic [31:0] m_mem [2][4096];
  bit          m_val [2][4096];

  task automatic model_step(input int k, input logic rst_n, input logic ren, input logic wen,
                            input logic [31:0] addr, input logic [31:0] store);
    int idx;
    if (!rst_n) begin
      m_st[k]  = 0;
      m_age[k] = 0;
      m_idx[k] = 0;
      m_wr[k]  = 1'b0;
      return;
    end
    if (m_st[k] == 2 && m_wr[k] && wen) begin
      m_mem[k][m_idx[k]] = store;
      m_val[k][m_idx[k]] = 1'b1;
    end
    if (!ren && !wen) begin
      m_st[k] = 0;
    end else if ((ren && wen) || addr >= 32'h0000_4000) begin
      m_st[k] = 3;
    end else begin
      idx = int'(addr >> 2);
      if (m_st[k] == 1 && idx == m_idx[k] && bit'(wen) == m_wr[k]) begin
        m_age[k]++;
      end else begin
        m_age[k] = 0;
        m_idx[k] = idx;
        m_wr[k]  = wen;
      end
      m_st[k] = (m_age[k] == m_lat[k]) ? 2 : 1;
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge nrst2);
    model_step(0, nrst2, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.ramstore);
  end

  initial forever begin
    @(posedge CLK or negedge nrst0);
    model_step(1, nrst0, b0.ramREN, b0.ramWEN, b0.ramaddr, b0.ramstore);
  end

  task automatic cmp(input int k, input logic [1:0] st, input logic [31:0] ld);
    chk($sformatf("model_state[%0d]", k), 32'(st), 32'(m_st[k]));
    if (m_st[k] == 2 && !m_wr[k]) begin
      if (m_val[k][m_idx[k]]) chk($sformatf("model_load[%0d]", k), ld, m_mem[k][m_idx[k]]);
    end else begin
      chk($sformatf("model_load_zero[%0d]", k), ld, 32'h0);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    cmp(0, b2.ramstate, b2.ramload);
    cmp(1, b0.ramstate, b0.ramload);
  end

  task automatic drive(input int k, input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
    if (k == 0) begin
      b2.ramREN = ren; b2.ramWEN = wen; b2.ramaddr = addr; b2.ramstore = data;
    end else begin
      b0.ramREN = ren; b0.ramWEN = wen; b0.ramaddr = addr; b0.ramstore = data;
    end
  endtask

  function automatic logic [1:0] st_of(input int k);
    return (k == 0) ? b2.ramstate : b0.ramstate;
  endfunction

  function automatic logic [31:0] ld_of(input int k);
    return (k == 0) ? b2.ramload : b0.ramload;
  endfunction

  task automatic step();
    @(posedge CLK);
    #3;
  endtask

  task automatic lit(input string name, input int k, input logic [1:0] st, input logic [31:0] ld);
    chk({name, "_state"}, 32'(st_of(k)), 32'(st));
    chk({name, "_load"}, ld_of(k), ld);
  endtask

  task automatic lit_st(input string name, input int k, input logic [1:0] st);
    chk({name, "_state"}, 32'(st_of(k)), 32'(st));
  endtask

  // Hold a request until ACCESS (bounded), run the ACCESS-ending edge, then go idle.
  task automatic do_access(input int k, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] seen);
    int n = 0;
    drive(k, ~wr, wr, addr, data);
    do begin
      step();
      n++;
    end while (st_of(k) != 2'd2 && n < 20);
    chk("access_reached", 32'(st_of(k)), 32'd2);
    seen = ld_of(k);
    step();
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seen;
    nrst2 = 1'b0;
    nrst0 = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #3;
    lit("reset_lat2", 0, 2'd0, 32'h0);
    lit("reset_lat0", 1, 2'd0, 32'h0);
    nrst2 = 1'b1;
    nrst0 = 1'b1;
    step();

    // Held write of 0x40 then read back, LAT=2
    drive(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    lit_st("w40_pre", 0, 2'd0);
    step(); lit_st("w40_b1", 0, 2'd1);
    step(); lit_st("w40_b2", 0, 2'd1);
    step(); lit("w40_acc", 0, 2'd2, 32'h0);
    step();
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    step(); lit_st("r40_b1", 0, 2'd1);
    step(); lit_st("r40_b2", 0, 2'd1);
    step(); lit("r40_acc", 0, 2'd2, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); lit("idle_free", 0, 2'd0, 32'h0);

    do_access(0, 1'b1, 32'h44, 32'h12345678, seen);

    // Address switch after one BUSY cycle restarts the latency
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    step(); lit_st("sw_b1", 0, 2'd1);
    drive(0, 1'b1, 1'b0, 32'h44, 32'h0);
    step(); lit_st("sw_b2", 0, 2'd1);
    step(); lit_st("sw_b3", 0, 2'd1);
    step(); lit("sw_acc", 0, 2'd2, 32'h12345678);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // LAT=0: write then held read, ACCESS on every edge
    drive(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    step(); lit("l0_w_acc", 1, 2'd2, 32'h0);
    step();
    drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); lit($sformatf("l0_r_acc%0d", i), 1, 2'd2, 32'hDEADBEEF);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); lit("l0_free", 1, 2'd0, 32'h0);

    // Both enables -> ERROR; dropping ramWEN starts a legal read
    drive(0, 1'b1, 1'b1, 32'h40, 32'h0);
    step(); lit("both_err1", 0, 2'd3, 32'h0);
    step(); lit("both_err2", 0, 2'd3, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    step(); lit_st("err_b1", 0, 2'd1);
    step(); lit_st("err_b2", 0, 2'd1);
    step(); lit("err_acc", 0, 2'd2, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Out-of-range addresses and the last legal word
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    step(); lit("oor_err", 0, 2'd3, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0);
    step(); lit("oor_edge_err", 0, 2'd3, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0000_3FFC, 32'h0);
    step(); lit_st("top_word_busy", 0, 2'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset during a BUSY write aborts it
    do_access(0, 1'b1, 32'h80, 32'hAAAA5555, seen);
    drive(0, 1'b0, 1'b1, 32'h80, 32'h0BADF00D);
    step(); lit_st("rw_busy", 0, 2'd1);
    nrst2 = 1'b0;
    #1;
    lit("rst_async", 0, 2'd0, 32'h0);
    step();
    step(); lit("rst_hold", 0, 2'd0, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    nrst2 = 1'b1;
    step();
    do_access(0, 1'b0, 32'h80, 32'h0, seen);
    chk("r80_old", seen, 32'hAAAA5555);

    // A request held across reset release starts afresh
    drive(0, 1'b1, 1'b0, 32'h80, 32'h0);
    step(); lit_st("held_b0", 0, 2'd1);
    nrst2 = 1'b0;
    #1;
    step();
    nrst2 = 1'b1;
    step(); lit_st("held_b1", 0, 2'd1);
    step(); lit_st("held_b2", 0, 2'd1);
    step(); lit("held_acc", 0, 2'd2, 32'hAAAA5555);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2: number of BUSY cycles before each ACCESS (0..15).
REQ-002 SHALL have parameter DEPTH, default 4096: memory size in 32-bit words, a power of two.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ramaddr, input, 32 bits: byte address; bits [1:0] are ignored and the word index is ramaddr[log2(DEPTH)+1:2].
REQ-006 SHALL have port ramstore, input, 32 bits: write data.
REQ-007 SHALL have port ramREN, input, 1 bit: read request, level-held by the requester.
REQ-008 SHALL have port ramWEN, input, 1 bit: write request, level-held by the requester.
REQ-009 SHALL have port ramload, output, 32 bits: read data.
REQ-010 SHALL have port ramstate, output, 2 bits: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 SHALL implement a state machine with states FREE, BUSY, ACCESS and ERROR, driven directly onto ramstate.
REQ-012 SHALL define a request as legal when exactly one of ramREN/ramWEN is high and ramaddr[31:log2(DEPTH)+2] is all zero.
REQ-013 SHALL define a request as illegal when both ramREN and ramWEN are high, or when either is high with a nonzero out-of-range address bit.
REQ-014 SHALL, on a clock edge with no request, move to FREE from any state.
REQ-015 SHALL, on a clock edge with an illegal request, move to ERROR from any state and remain there while the request stays illegal.
REQ-016 SHALL, on a legal request in FREE or ERROR, latch the word address and type and load the counter with LAT.
REQ-017 SHALL, at that same edge, enter BUSY if LAT>0, or enter ACCESS directly if LAT=0.
REQ-018 SHALL, in BUSY, decrement the counter each edge and enter ACCESS at the edge where the counter reaches 0, so that exactly LAT BUSY cycles precede ACCESS.
REQ-019 SHALL, in BUSY, treat a change of word address or request type as a new request: relatch, reload the counter and remain in BUSY; this takes precedence over REQ-018.
REQ-020 SHALL last exactly one cycle in ACCESS; with a legal request at the next edge it behaves as from FREE (a held request starts a new access).
REQ-021 SHALL, for a write, update mem[latched index] with ramstore at the edge that ends the ACCESS cycle, provided ramWEN is still high.
REQ-022 SHALL drive ramload = mem[latched index] combinationally during a read ACCESS cycle, and 32'h0 otherwise.
REQ-023 SHALL reflect a write in ACCESS at cycle n in a read ACCESS at any cycle >= n+1 (read-after-write).
REQ-024 SHALL use a counter 4 bits wide with no wrap below 0.

Reset
REQ-025 SHALL, while nRST=0, force state FREE, counter 0, latched address and type 0, ramstate=FREE and ramload=0, immediately and without waiting for CLK.
REQ-026 SHALL leave memory contents unaffected by reset.
REQ-027 SHALL abort any in-flight access on reset mid-operation, with no memory write.
REQ-028 SHALL, after nRST rises, treat a held request as new and start from FREE.

Verification
REQ-029 SHALL be tested with LAT=2: write 0x40 = 0xDEADBEEF held -> ramstate FREE, BUSY, BUSY, ACCESS; then read 0x40 -> BUSY, BUSY, ACCESS with ramload=0xDEADBEEF.
REQ-030 SHALL be tested with LAT=0: read 0x40 -> ACCESS on the first edge, ACCESS on every edge while held, ramload=0xDEADBEEF each cycle.
REQ-031 SHALL be tested with LAT=2: read 0x40, then switch to 0x44 after one BUSY cycle -> counter restarts, two more BUSY cycles, then ACCESS returns mem[0x44].
REQ-032 SHALL be tested with ramREN=ramWEN=1 -> ERROR; then ramWEN dropped -> legal read starts with BUSY.
REQ-033 SHALL be tested with a read of address 0x00010000 at DEPTH=4096 -> ERROR and ramload=0.
REQ-034 SHALL be tested with a write to 0x80 and nRST pulsed low during BUSY -> ramstate=FREE immediately; a later read of 0x80 returns the old value.
